// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and defaults for the game sequencer
package game_pkg;

    localparam int CNT_W = 10;
    localparam int DEF_ENEMY_NUM = 4;
    localparam logic [6:0] DEF_PLAYER_FULL_BLOOD = 7'd100;

    typedef enum logic [2:0] {
        IDLE,
        PLAY,
        SCAN,
        WAVE_BREAK,
        GAME_OVER
    } game_state_t;

    // SCAN is an internal sub-phase of PLAY and reports as PLAY externally
    function automatic logic [1:0] state_code(input game_state_t s);
        case (s)
            IDLE:       return 2'd0;
            PLAY:       return 2'd1;
            SCAN:       return 2'd1;
            WAVE_BREAK: return 2'd2;
            GAME_OVER:  return 2'd3;
            default:    return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/game_if.sv
// rtl/game_if.sv - enemy counter bus and player status outputs
interface game_if #(
    parameter int ENEMY_NUM = 4
);
    logic [ENEMY_NUM*10-1:0] Enemy_Total_Damage_All;
    logic [ENEMY_NUM*10-1:0] Enemy_Score_All;
    logic [9:0]              Enemy_Respawn_Unit_Time;
    logic                    Enemy_Enable;
    logic [6:0]              Player_Blood;
    logic [9:0]              Total_Score;
    logic [3:0]              Wave;
    logic [1:0]              Game_State;

    modport master (
        input  Enemy_Total_Damage_All,
        input  Enemy_Score_All,
        output Enemy_Respawn_Unit_Time,
        output Enemy_Enable,
        output Player_Blood,
        output Total_Score,
        output Wave,
        output Game_State
    );

    modport slave (
        output Enemy_Total_Damage_All,
        output Enemy_Score_All,
        input  Enemy_Respawn_Unit_Time,
        input  Enemy_Enable,
        input  Player_Blood,
        input  Total_Score,
        input  Wave,
        input  Game_State
    );
endinterface

// File: rtl/enemy_delta_scanner.sv
// rtl/enemy_delta_scanner.sv - per-enemy counter snapshots and sequential delta scan
module enemy_delta_scanner
    import game_pkg::*;
#(
    parameter int ENEMY_NUM = DEF_ENEMY_NUM
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       track,
    input  logic                       scan_start,
    input  logic [ENEMY_NUM*CNT_W-1:0] damage_all,
    input  logic [ENEMY_NUM*CNT_W-1:0] score_all,
    output logic [CNT_W-1:0]           dd,
    output logic [CNT_W-1:0]           ds,
    output logic                       scan_valid,
    output logic                       scan_done
);

    localparam int IW = (ENEMY_NUM > 1) ? $clog2(ENEMY_NUM) : 1;
    localparam logic [IW-1:0] LAST = IW'(ENEMY_NUM - 1);

    logic [CNT_W-1:0] prev_damage [ENEMY_NUM];
    logic [CNT_W-1:0] prev_score  [ENEMY_NUM];
    logic [IW-1:0]    idx;
    logic [CNT_W-1:0] cur_damage;
    logic [CNT_W-1:0] cur_score;

    // Modular subtraction makes a counter wrap produce the true delta
    always_comb begin
        cur_damage = damage_all[idx*CNT_W +: CNT_W];
        cur_score  = score_all[idx*CNT_W +: CNT_W];
        dd         = cur_damage - prev_damage[idx];
        ds         = cur_score - prev_score[idx];
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < ENEMY_NUM; i++) begin
                prev_damage[i] <= damage_all[i*CNT_W +: CNT_W];
                prev_score[i]  <= score_all[i*CNT_W +: CNT_W];
            end
            idx        <= '0;
            scan_valid <= 1'b0;
            scan_done  <= 1'b0;
        end else begin
            scan_done <= scan_valid && (idx == LAST);
            if (track) begin
                for (int i = 0; i < ENEMY_NUM; i++) begin
                    prev_damage[i] <= damage_all[i*CNT_W +: CNT_W];
                    prev_score[i]  <= score_all[i*CNT_W +: CNT_W];
                end
            end else if (scan_valid) begin
                prev_damage[idx] <= cur_damage;
                prev_score[idx]  <= cur_score;
            end
            if (scan_start) begin
                idx        <= '0;
                scan_valid <= 1'b1;
            end else if (scan_valid) begin
                if (idx == LAST) begin
                    scan_valid <= 1'b0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/game_controller.sv
// rtl/game_controller.sv - game flow FSM, blood/score accounting and wave progression
module game_controller
    import game_pkg::*;
#(
    parameter int         ENEMY_NUM         = DEF_ENEMY_NUM,
    parameter logic [6:0] PLAYER_FULL_BLOOD = DEF_PLAYER_FULL_BLOOD,
    parameter int         KILLS_PER_WAVE    = 8,
    parameter int         BASE_RESPAWN      = 60,
    parameter int         RESPAWN_STEP      = 10,
    parameter int         MIN_RESPAWN       = 10,
    parameter int         BREAK_FRAMES      = 120,
    parameter int         MAX_WAVE          = 9
) (
    input  logic Clk,
    input  logic Reset,
    input  logic game_frame_clk_rising_edge,
    input  logic Start,
    game_if.master bus
);

    localparam int BW = $clog2(BREAK_FRAMES + 1);

    game_state_t      state, state_n;
    logic [6:0]       blood_n;
    logic [9:0]       score_n;
    logic [3:0]       wave_n;
    logic [9:0]       resp_n;
    logic [7:0]       kills, kills_n;
    logic [BW-1:0]    brk, brk_n;
    logic             scan_start, scan_valid, scan_done, track;
    logic [CNT_W-1:0] dd, ds;
    logic [10:0]      score_sum, kill_sum;

    function automatic logic [9:0] respawn_for(input logic [3:0] w);
        int r;
        r = BASE_RESPAWN - RESPAWN_STEP * (int'(w) - 1);
        return (r < MIN_RESPAWN) ? 10'(MIN_RESPAWN) : 10'(r);
    endfunction

    assign track = (state == IDLE) || (state == WAVE_BREAK) || (state == GAME_OVER);

    enemy_delta_scanner #(.ENEMY_NUM(ENEMY_NUM)) u_scanner (
        .Clk        (Clk),
        .Reset      (Reset),
        .track      (track),
        .scan_start (scan_start),
        .damage_all (bus.Enemy_Total_Damage_All),
        .score_all  (bus.Enemy_Score_All),
        .dd         (dd),
        .ds         (ds),
        .scan_valid (scan_valid),
        .scan_done  (scan_done)
    );

    always_comb begin
        state_n    = state;
        blood_n    = bus.Player_Blood;
        score_n    = bus.Total_Score;
        wave_n     = bus.Wave;
        resp_n     = bus.Enemy_Respawn_Unit_Time;
        kills_n    = kills;
        brk_n      = brk;
        scan_start = 1'b0;
        score_sum  = {1'b0, bus.Total_Score} + {1'b0, ds};
        kill_sum   = {3'b0, kills} + {1'b0, ds};
        case (state)
            IDLE, GAME_OVER: begin
                if (Start) begin
                    state_n = PLAY;
                    blood_n = PLAYER_FULL_BLOOD;
                    score_n = '0;
                    wave_n  = 4'd1;
                    resp_n  = 10'(BASE_RESPAWN);
                    kills_n = '0;
                    brk_n   = '0;
                end
            end
            PLAY: begin
                if (game_frame_clk_rising_edge) begin
                    state_n    = SCAN;
                    scan_start = 1'b1;
                end
            end
            SCAN: begin
                if (scan_valid) begin
                    blood_n = ({1'b0, dd} >= {4'b0, bus.Player_Blood}) ? 7'd0
                            : bus.Player_Blood - dd[6:0];
                    score_n = (score_sum > 11'd999) ? 10'd999 : score_sum[9:0];
                    kills_n = (kill_sum > 11'd255) ? 8'd255 : kill_sum[7:0];
                end
                if (scan_done) begin
                    if (bus.Player_Blood == 7'd0) begin
                        state_n = GAME_OVER;
                    end else if (kills >= 8'(KILLS_PER_WAVE)) begin
                        state_n = WAVE_BREAK;
                        kills_n = '0;
                        brk_n   = '0;
                    end else begin
                        state_n = PLAY;
                    end
                end
            end
            WAVE_BREAK: begin
                if (game_frame_clk_rising_edge) begin
                    if (brk == BW'(BREAK_FRAMES - 1)) begin
                        wave_n  = (bus.Wave >= 4'(MAX_WAVE)) ? 4'(MAX_WAVE) : bus.Wave + 4'd1;
                        resp_n  = respawn_for(wave_n);
                        state_n = PLAY;
                    end else begin
                        brk_n = brk + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state                       <= IDLE;
            bus.Player_Blood            <= PLAYER_FULL_BLOOD;
            bus.Total_Score             <= '0;
            bus.Wave                    <= 4'd1;
            bus.Enemy_Respawn_Unit_Time <= 10'(BASE_RESPAWN);
            bus.Enemy_Enable            <= 1'b0;
            bus.Game_State              <= 2'd0;
            kills                       <= '0;
            brk                         <= '0;
        end else begin
            state                       <= state_n;
            bus.Player_Blood            <= blood_n;
            bus.Total_Score             <= score_n;
            bus.Wave                    <= wave_n;
            bus.Enemy_Respawn_Unit_Time <= resp_n;
            bus.Enemy_Enable            <= (state_n == PLAY) || (state_n == SCAN);
            bus.Game_State              <= state_code(state_n);
            kills                       <= kills_n;
            brk                         <= brk_n;
        end
    end

endmodule

// File: tb/tb_game_controller.sv
// tb/tb_game_controller.sv - randomized scoreboard bench for game_controller
module tb_game_controller;
    localparam int N = 4;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic frame = 1'b0;
    logic Start = 1'b0;

    game_if #(.ENEMY_NUM(N)) bus();

    game_controller #(.ENEMY_NUM(N)) dut (
        .Clk                        (Clk),
        .Reset                      (Reset),
        .game_frame_clk_rising_edge (frame),
        .Start                      (Start),
        .bus                        (bus)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int due;
        int state;
        int blood;
        int score;
        int wave;
        int resp;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_err = 0;

    int dmg[N];
    int scr[N];
    int pd[N];
    int ps[N];
    int m_state, m_blood, m_score, m_wave, m_resp, m_kills, m_brk;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compare each expected record in the cycle it is due
    initial begin
        forever begin
            @(negedge Clk);
            while (q.size() > 0 && q[0].due <= cyc) begin
                exp_t e;
                e = q.pop_front();
                if (e.due < cyc) begin
                    check("missed_slot", cyc, e.due);
                end else begin
                    check("game_state", int'(bus.Game_State), e.state);
                    check("enemy_enable", int'(bus.Enemy_Enable), (e.state == 1) ? 1 : 0);
                    check("player_blood", int'(bus.Player_Blood), e.blood);
                    check("total_score", int'(bus.Total_Score), e.score);
                    check("wave", int'(bus.Wave), e.wave);
                    check("respawn", int'(bus.Enemy_Respawn_Unit_Time), e.resp);
                end
            end
        end
    end

    task automatic push(input int lat);
        exp_t e;
        e.due   = cyc + 1 + lat;
        e.state = m_state;
        e.blood = m_blood;
        e.score = m_score;
        e.wave  = m_wave;
        e.resp  = m_resp;
        q.push_back(e);
    endtask

    // Outside play the DUT follows the counters, so nothing is ever charged
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            dmg[i] = dmg[i] & 1023;
            scr[i] = scr[i] & 1023;
            bus.Enemy_Total_Damage_All[i*10 +: 10] = 10'(dmg[i]);
            bus.Enemy_Score_All[i*10 +: 10]        = 10'(scr[i]);
            if (m_state != 1) begin
                pd[i] = dmg[i];
                ps[i] = scr[i];
            end
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_blood = 100; m_score = 0; m_wave = 1;
        m_resp = 60; m_kills = 0; m_brk = 0;
        for (int i = 0; i < N; i++) begin
            pd[i] = dmg[i];
            ps[i] = scr[i];
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        model_reset();
        push(0);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic do_start();
        @(negedge Clk);
        Start = 1'b1;
        if (m_state == 0 || m_state == 3) begin
            m_state = 1; m_blood = 100; m_score = 0; m_wave = 1;
            m_resp = 60; m_kills = 0; m_brk = 0;
        end
        push(0);
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic do_frame();
        int gap;
        @(negedge Clk);
        frame = 1'b1;
        gap = 1;
        if (m_state == 1) begin
            for (int i = 0; i < N; i++) begin
                int d, s;
                d = (dmg[i] - pd[i] + 1024) % 1024;
                s = (scr[i] - ps[i] + 1024) % 1024;
                m_blood = (d >= m_blood) ? 0 : m_blood - d;
                m_score = (m_score + s > 999) ? 999 : m_score + s;
                m_kills = (m_kills + s > 255) ? 255 : m_kills + s;
                pd[i] = dmg[i];
                ps[i] = scr[i];
            end
            if (m_blood == 0) begin
                m_state = 3;
            end else if (m_kills >= 8) begin
                m_state = 2; m_kills = 0; m_brk = 0;
            end
            push(N + 1);
            gap = N + 3;
        end else if (m_state == 2) begin
            if (m_brk == 119) begin
                m_wave  = (m_wave + 1 > 9) ? 9 : m_wave + 1;
                m_resp  = (60 - 10 * (m_wave - 1) < 10) ? 10 : 60 - 10 * (m_wave - 1);
                m_state = 1;
            end else begin
                m_brk++;
            end
            push(0);
        end else begin
            push(0);
        end
        @(negedge Clk);
        frame = 1'b0;
        repeat (gap) @(negedge Clk);
    endtask

    // Frame pulse, then reset while the scanner is on enemy 1
    task automatic reset_mid_scan();
        @(negedge Clk);
        frame = 1'b1;
        @(negedge Clk);
        frame = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        model_reset();
        push(0);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: cycle %0d reached, limit 50000", cyc);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            dmg[i] = 0;
            scr[i] = 0;
        end
        m_state = 0;
        drive();
        do_reset();

        dmg[0] = 1020; drive();
        do_start();
        dmg[2] += 10; drive(); do_frame();
        dmg[0] = 4; drive(); do_frame();

        dmg[1] += 50; dmg[3] += 40; dmg[2] += 20; drive(); do_frame();
        dmg[1] += 5; drive(); do_frame();
        do_start();
        do_frame();

        scr[0] += 3; drive(); do_frame();
        scr[1] += 2; scr[3] += 1; drive(); do_frame();
        scr[2] += 2; drive(); do_frame();
        scr[0] += 5; drive();
        repeat (120) do_frame();
        do_frame();

        repeat (9) begin
            int k;
            k = $urandom_range(0, N - 1);
            scr[k] += 8; drive(); do_frame();
            repeat (120) do_frame();
        end

        dmg[1] += 3; drive(); do_frame();
        dmg[1] += 7; scr[2] += 1; drive();
        reset_mid_scan();

        for (int i = 0; i < N; i++) dmg[i] = $urandom_range(1015, 1023);
        drive();
        repeat (150) begin
            if ($urandom_range(0, 9) < 6) begin
                for (int i = 0; i < N; i++) begin
                    if ($urandom_range(0, 1) == 1) dmg[i] += $urandom_range(0, 6);
                    if ($urandom_range(0, 2) == 0) scr[i] += $urandom_range(0, 2);
                end
                drive();
            end
            if (m_state == 0 || m_state == 3) do_start();
            do_frame();
        end

        repeat (20) @(negedge Clk);
        check("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
